// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 style adder/subtractor for half or single
// precision. Results are truncated, denormals are flushed to zero and there is
// no rounding.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   START             request an operation (sampled only while idle)
//   MODE_FP           0 = half (bits [15:0]), 1 = single precision
//   OP_CODE           000 = add, 001 = sub, anything else returns NaN
//   OP_A, OP_B        operands
//   busy              operation in flight
//   done              one-cycle completion pulse
//   result            packed result ([31:16] = 0 in half mode)
//   flags             00001 NaN, 11111 inf, 00010 ovf, 00011 unf, 10000 denorm
//
// Optional feature (macro FP_STICKY_FLAGS_EN):
//   CLR_FLAGS         clears sticky_flags on the next edge (wins over update)
//   sticky_flags      OR of flags from every completed operation
module fp_addsub_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        MODE_FP,
    input  logic [2:0]  OP_CODE,
    input  logic [31:0] OP_A,
    input  logic [31:0] OP_B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  flags
`ifdef FP_STICKY_FLAGS_EN
    ,
    input  logic        CLR_FLAGS,
    output logic [4:0]  sticky_flags
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_EXEC, S_NORM, S_PACK} state_t;

    // Half-precision mantissas are left-aligned into the 24-bit field so one
    // datapath serves both formats.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        nan;
        logic        inf;
        logic        den;
    } unp_t;

    function automatic unp_t unpack(input logic mode, input logic [31:0] w);
        unp_t        u;
        logic [7:0]  e;
        logic [22:0] f;
        logic        emax;
        if (mode) begin
            u.sign = w[31];
            e      = w[30:23];
            f      = w[22:0];
            emax   = (e == 8'hFF);
        end else begin
            u.sign = w[15];
            e      = {3'b000, w[14:10]};
            f      = {w[9:0], 13'b0};
            emax   = (e == 8'd31);
        end
        u.nan  = emax && (f != 23'd0);
        u.inf  = emax && (f == 23'd0);
        u.den  = (e == 8'd0) && (f != 23'd0);
        u.exp  = e;
        u.mant = (e == 8'd0) ? 24'd0 : {1'b1, f};
        return u;
    endfunction

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (m[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // Returns {flags, result}; saturates to infinity / flushes to zero.
    function automatic logic [36:0] pack_norm(input logic mode, input logic s,
                                              input logic signed [9:0] e,
                                              input logic [23:0] m);
        if (mode) begin
            if (e >= 10'sd255)
                return {5'b00010, s, 8'hFF, 23'd0};
            else if ((e <= 10'sd0) && (m != 24'd0))
                return {5'b00011, s, 31'd0};
            else
                return {5'b00000, s, e[7:0], m[22:0]};
        end else begin
            if (e >= 10'sd31)
                return {5'b00010, 16'd0, s, 5'h1F, 10'd0};
            else if ((e <= 10'sd0) && (m != 24'd0))
                return {5'b00011, 16'd0, s, 15'd0};
            else
                return {5'b00000, 16'd0, s, e[4:0], m[22:13]};
        end
    endfunction

    state_t r_state;

    logic        r_mode;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    logic        r_sa_p1, r_sb_p1;
    logic [7:0]  r_ea_p1, r_eb_p1;
    logic [23:0] r_ma_p1, r_mb_p1;
    logic        r_nan_p1, r_inf_p1, r_inf_s_p1, r_den_p1;

    logic [7:0]  r_e_p2;
    logic [23:0] r_mbig_p2, r_msml_p2;
    logic        r_sign_p2, r_sub_p2;

    logic [24:0] r_sum_p3;
    logic [7:0]  r_e_p3;
    logic        r_sign_p3;

    logic signed [9:0] r_e_p4;
    logic [23:0]       r_m_p4;
    logic              r_sign_p4;

    unp_t        w_ua, w_ub;
    logic        w_a_big;
    logic [7:0]  w_diff;
    logic [23:0] w_small_raw, w_small;
    logic [24:0] w_sum;
    logic [4:0]  w_lz;
    logic [23:0] w_norm_m;
    logic signed [9:0] w_norm_e;
    logic        w_norm_s;
    logic [36:0] w_packed;
    logic [31:0] w_res;
    logic [4:0]  w_flags;

    assign w_ua = unpack(r_mode, r_a);
    assign w_ub = unpack(r_mode, r_b);

    assign w_a_big     = (r_ea_p1 > r_eb_p1) || ((r_ea_p1 == r_eb_p1) && (r_ma_p1 >= r_mb_p1));
    assign w_diff      = w_a_big ? (r_ea_p1 - r_eb_p1) : (r_eb_p1 - r_ea_p1);
    assign w_small_raw = w_a_big ? r_mb_p1 : r_ma_p1;
    // Masking the unused low bits in half mode keeps truncation at 11 bits.
    assign w_small     = (w_diff >= 8'd25) ? 24'd0 :
                         ((w_small_raw >> w_diff) & (r_mode ? 24'hFFFFFF : 24'hFFE000));

    assign w_sum = r_sub_p2 ? ({1'b0, r_mbig_p2} - {1'b0, r_msml_p2})
                            : ({1'b0, r_mbig_p2} + {1'b0, r_msml_p2});

    assign w_lz = lzc24(r_sum_p3[23:0]);

    always_comb begin
        w_norm_m = r_sum_p3[24:1];
        w_norm_e = $signed({2'b00, r_e_p3}) + 10'sd1;
        w_norm_s = r_sign_p3;
        if (!r_sum_p3[24]) begin
            if (r_sum_p3[23:0] == 24'd0) begin
                w_norm_m = 24'd0;
                w_norm_e = 10'sd0;
                w_norm_s = 1'b0;
            end else begin
                w_norm_m = r_sum_p3[23:0] << w_lz;
                w_norm_e = $signed({2'b00, r_e_p3}) - $signed({5'b00000, w_lz});
            end
        end
    end

    assign w_packed = pack_norm(r_mode, r_sign_p4, r_e_p4, r_m_p4);

    always_comb begin
        w_res   = w_packed[31:0];
        w_flags = w_packed[36:32];
        if (r_nan_p1) begin
            w_res   = r_mode ? 32'h7FC00000 : 32'h00007E00;
            w_flags = 5'b00001;
        end else if (r_inf_p1) begin
            w_res   = r_mode ? {r_inf_s_p1, 8'hFF, 23'd0} : {16'd0, r_inf_s_p1, 5'h1F, 10'd0};
            w_flags = 5'b11111;
        end else if ((w_flags == 5'b00000) && r_den_p1) begin
            w_flags = 5'b10000;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 32'd0;
            flags   <= 5'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (START) begin
                    r_state <= S_UNPACK;
                    busy    <= 1'b1;
                end
                S_UNPACK: r_state <= S_ALIGN;
                S_ALIGN:  r_state <= S_EXEC;
                S_EXEC:   r_state <= S_NORM;
                S_NORM:   r_state <= S_PACK;
                S_PACK: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    result  <= w_res;
                    flags   <= w_flags;
                end
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        case (r_state)
            S_IDLE: if (START) begin
                r_mode <= MODE_FP;
                r_op   <= OP_CODE;
                r_a    <= OP_A;
                r_b    <= OP_B;
            end
            // unpack -> p1
            S_UNPACK: begin
                r_sa_p1    <= w_ua.sign;
                r_sb_p1    <= w_ub.sign ^ r_op[0];
                r_ea_p1    <= w_ua.exp;
                r_eb_p1    <= w_ub.exp;
                r_ma_p1    <= w_ua.mant;
                r_mb_p1    <= w_ub.mant;
                r_nan_p1   <= (r_op[2:1] != 2'b00) || w_ua.nan || w_ub.nan ||
                              (w_ua.inf && w_ub.inf && (w_ua.sign != (w_ub.sign ^ r_op[0])));
                r_inf_p1   <= w_ua.inf || w_ub.inf;
                r_inf_s_p1 <= w_ua.inf ? w_ua.sign : (w_ub.sign ^ r_op[0]);
                r_den_p1   <= w_ua.den || w_ub.den;
            end
            // align -> p2
            S_ALIGN: begin
                r_e_p2    <= w_a_big ? r_ea_p1 : r_eb_p1;
                r_mbig_p2 <= w_a_big ? r_ma_p1 : r_mb_p1;
                r_msml_p2 <= w_small;
                r_sign_p2 <= w_a_big ? r_sa_p1 : r_sb_p1;
                r_sub_p2  <= r_sa_p1 ^ r_sb_p1;
            end
            // exec -> p3
            S_EXEC: begin
                r_sum_p3  <= w_sum;
                r_e_p3    <= r_e_p2;
                r_sign_p3 <= r_sign_p2;
            end
            // normalize -> p4
            S_NORM: begin
                r_m_p4    <= w_norm_m;
                r_e_p4    <= w_norm_e;
                r_sign_p4 <= w_norm_s;
            end
            default: ;
        endcase
    end

`ifdef FP_STICKY_FLAGS_EN
    logic [4:0] r_sticky;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_sticky <= 5'd0;
        else if (CLR_FLAGS)
            r_sticky <= 5'd0;
        else if (done)
            r_sticky <= r_sticky | flags;
    end

    assign sticky_flags = r_sticky;
`endif

endmodule
